// File: rtl/i2c_master_word_ctrl_if.sv
// Command/status and bit-controller signal bundle for the multi-byte I2C word controller.
// Latency: pure wiring, no storage.
// Backpressure: the host holds a command until cmd_ack; the bit controller paces each bit with core_ack.
interface i2c_master_word_ctrl_if #(
    parameter int NBYTES = 2,
    parameter int LEN_W  = 4
);
    // host command side
    logic                  start;
    logic                  stop;
    logic                  read;
    logic                  write;
    logic                  ack_in;
    logic [LEN_W-1:0]      len;
    logic [8*NBYTES-1:0]   din;
    // host status side
    logic                  cmd_ack;
    logic                  ack_out;
    logic [NBYTES-1:0]     ack_vec;
    logic [8*NBYTES-1:0]   dout;
    logic                  busy;
    logic                  nack_abort;
    // bit-controller side
    logic [3:0]            core_cmd;
    logic                  core_txd;
    logic                  core_ack;
    logic                  core_rxd;
    logic                  core_al;

    // word controller view
    modport slave (
        input  start, stop, read, write, ack_in, len, din,
        output cmd_ack, ack_out, ack_vec, dout, busy, nack_abort,
        output core_cmd, core_txd,
        input  core_ack, core_rxd, core_al
    );

    // host / bit-controller view
    modport master (
        output start, stop, read, write, ack_in, len, din,
        input  cmd_ack, ack_out, ack_vec, dout, busy, nack_abort,
        input  core_cmd, core_txd,
        output core_ack, core_rxd, core_al
    );
endinterface

// File: rtl/i2c_master_word_ctrl.sv
// I2C multi-byte command sequencer: turns one host command into START/byte/ACK/STOP bit commands.
// Latency: command accepted the cycle after go; cmd_ack pulses one cycle after the final core_ack.
// Backpressure: each bit waits for core_ack; host holds command inputs until cmd_ack. Macro I2C_WORD_NACK_ABORT_EN enables write abort on slave NACK.
module i2c_master_word_ctrl #(
    parameter int NBYTES = 2,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  rst,
    i2c_master_word_ctrl_if.slave bus
);
    localparam int SR_W = 8 * NBYTES;
    localparam int BC_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

`ifdef I2C_WORD_NACK_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        core_cmd_q, core_cmd_d;
    logic              core_txd_q, core_txd_d;
    logic              cmd_ack_q, cmd_ack_d;
    logic              ack_out_q, ack_out_d;
    logic [NBYTES-1:0] ack_vec_q, ack_vec_d;
    logic [SR_W-1:0]   sr_q, sr_d, sr_load;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic              nack_abort_q, nack_abort_d;
    logic              rd_q, rd_d;      // command is a read (read has priority over write)
    logic              stop_q, stop_d;  // finish with a STOP condition
    logic [31:0]       len_x, len_eff;
    logic              go, last_byte, abort;

    assign go = (bus.read | bus.write | bus.stop) & ~cmd_ack_q & (state_q == S_IDLE);

    // Effective byte count and left-alignment of write data into the shift register.
    always_comb begin
        len_x   = 32'(bus.len);
        len_eff = (len_x == 32'd0 || len_x > 32'(NBYTES)) ? 32'(NBYTES) : len_x;
        sr_load = bus.read ? '0 : (bus.din << (8 * (32'(NBYTES) - len_eff)));
    end

    // Next-state, bit-command and datapath updates; arbitration loss and sync reset take priority.
    always_comb begin
        state_d      = state_q;
        core_cmd_d   = core_cmd_q;
        core_txd_d   = core_txd_q;
        cmd_ack_d    = 1'b0;
        ack_out_d    = ack_out_q;
        ack_vec_d    = ack_vec_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        nack_abort_d = nack_abort_q;
        rd_d         = rd_q;
        stop_d       = stop_q;
        last_byte    = (byte_cnt_q == '0);
        abort        = 1'b0;

        if (rst) begin
            state_d      = S_IDLE;
            core_cmd_d   = CMD_NOP;
            core_txd_d   = 1'b0;
            ack_out_d    = 1'b0;
            ack_vec_d    = '1;
            sr_d         = '0;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            nack_abort_d = 1'b0;
            rd_d         = 1'b0;
            stop_d       = 1'b0;
        end else if (bus.core_al) begin
            // lost the bus: drop everything, keep captured data for inspection
            state_d    = S_IDLE;
            core_cmd_d = CMD_NOP;
            core_txd_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        sr_d         = sr_load;
                        bit_cnt_d    = 3'd7;
                        byte_cnt_d   = BC_W'(len_eff - 32'd1);
                        ack_vec_d    = '1;
                        nack_abort_d = 1'b0;
                        rd_d         = bus.read;
                        stop_d       = bus.stop;
                        if (bus.start) begin
                            state_d    = S_START;
                            core_cmd_d = CMD_START;
                        end else if (bus.read) begin
                            state_d    = S_READ;
                            core_cmd_d = CMD_READ;
                        end else if (bus.write) begin
                            state_d    = S_WRITE;
                            core_cmd_d = CMD_WRITE;
                            core_txd_d = sr_load[SR_W-1];
                        end else begin
                            state_d    = S_STOP;
                            core_cmd_d = CMD_STOP;
                        end
                    end
                end
                S_START: begin
                    if (bus.core_ack) begin
                        bit_cnt_d = 3'd7;
                        if (rd_q) begin
                            state_d    = S_READ;
                            core_cmd_d = CMD_READ;
                        end else begin
                            state_d    = S_WRITE;
                            core_cmd_d = CMD_WRITE;
                            core_txd_d = sr_q[SR_W-1];
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.core_ack) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d    = S_ACK;
                            core_cmd_d = CMD_READ;
                        end else begin
                            sr_d       = sr_q << 1;
                            bit_cnt_d  = bit_cnt_q - 3'd1;
                            core_txd_d = sr_q[SR_W-2];
                        end
                    end
                end
                S_READ: begin
                    if (bus.core_ack) begin
                        sr_d = {sr_q[SR_W-2:0], bus.core_rxd};
                        if (bit_cnt_q == 3'd0) begin
                            state_d    = S_ACK;
                            core_cmd_d = CMD_WRITE;
                            // master ACKs every byte but the last, which gets the host's ack_in
                            core_txd_d = last_byte ? bus.ack_in : 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (bus.core_ack) begin
                        ack_out_d = bus.core_rxd;
                        if (!rd_q) begin
                            ack_vec_d[byte_cnt_q] = bus.core_rxd;
                        end
                        abort = ABORT_EN && !rd_q && bus.core_rxd && !last_byte;
                        if (!last_byte && !abort) begin
                            byte_cnt_d = byte_cnt_q - 1'b1;
                            bit_cnt_d  = 3'd7;
                            if (rd_q) begin
                                state_d    = S_READ;
                                core_cmd_d = CMD_READ;
                            end else begin
                                state_d    = S_WRITE;
                                core_cmd_d = CMD_WRITE;
                                sr_d       = sr_q << 1;
                                core_txd_d = sr_q[SR_W-2];
                            end
                        end else begin
                            if (abort) begin
                                nack_abort_d = 1'b1;
                            end
                            core_txd_d = 1'b0;
                            if (stop_q) begin
                                state_d    = S_STOP;
                                core_cmd_d = CMD_STOP;
                            end else begin
                                state_d    = S_IDLE;
                                core_cmd_d = CMD_NOP;
                                cmd_ack_d  = 1'b1;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (bus.core_ack) begin
                        state_d    = S_IDLE;
                        core_cmd_d = CMD_NOP;
                        core_txd_d = 1'b0;
                        cmd_ack_d  = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    core_cmd_d = CMD_NOP;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            core_cmd_q   <= CMD_NOP;
            core_txd_q   <= 1'b0;
            cmd_ack_q    <= 1'b0;
            ack_out_q    <= 1'b0;
            ack_vec_q    <= '1;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            nack_abort_q <= 1'b0;
            rd_q         <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_cmd_q   <= core_cmd_d;
            core_txd_q   <= core_txd_d;
            cmd_ack_q    <= cmd_ack_d;
            ack_out_q    <= ack_out_d;
            ack_vec_q    <= ack_vec_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            nack_abort_q <= nack_abort_d;
            rd_q         <= rd_d;
            stop_q       <= stop_d;
        end
    end

    assign bus.core_cmd   = core_cmd_q;
    assign bus.core_txd   = core_txd_q;
    assign bus.cmd_ack    = cmd_ack_q;
    assign bus.ack_out    = ack_out_q;
    assign bus.ack_vec    = ack_vec_q;
    assign bus.dout       = sr_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.nack_abort = ABORT_EN ? nack_abort_q : 1'b0;
endmodule

// File: doc/i2c_master_word_ctrl.md
I2C_MASTER_WORD_CTRL -- requirements
Module: i2c_master_word_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 2, maximum bytes per command (legal 1..8).
REQ-002 SHALL have parameter LEN_W, default 4, width of len input.
REQ-003 SHALL have ports: clk input 1, master clock; nReset input 1, reset (one clock; reset is asynchronous and active-low).
REQ-004 SHALL have ports: rst input 1, synchronous active-high reset.
REQ-005 SHALL have command ports: start, stop, read, write, ack_in input 1 each; len input LEN_W, byte count; din input 8*NBYTES, write data.
REQ-006 SHALL have status ports: cmd_ack output 1, done pulse; ack_out output 1, last received ack bit; ack_vec output NBYTES, per-byte slave ack; dout output 8*NBYTES, read data; busy output 1, FSM not idle; nack_abort output 1, write aborted.
REQ-007 SHALL have bit-controller ports: core_cmd output 4, bit command; core_txd output 1, bit to send; core_ack input 1, bit done; core_rxd input 1, bit received; core_al input 1, arbitration lost.

Function
REQ-008 SHALL encode core_cmd as NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000.
REQ-009 SHALL take effective length L = len, except len==0 or len>NBYTES gives L = NBYTES.
REQ-010 SHALL accept a command when go = (read|write|stop) & ~cmd_ack in IDLE, and load on that cycle: shift register sr <= din << 8*(NBYTES-L) for write, sr <= 0 for read; bit counter <= 7; byte counter <= L-1; ack_vec <= all ones; nack_abort <= 0.
REQ-011 SHALL use states IDLE, START, WRITE, READ, ACK, STOP; busy = (state != IDLE).
REQ-012 IDLE + go SHALL go to START (cmd START) if start, else READ, else WRITE, else STOP, with the matching command.
REQ-013 START + core_ack SHALL go to READ if read, else WRITE; bit counter reloaded to 7.
REQ-014 WRITE SHALL drive core_txd = sr MSB (registered); core_ack with bit counter 0 -> ACK, cmd READ; otherwise shift sr left 1, decrement counter, stay.
REQ-015 READ + core_ack SHALL shift core_rxd into sr LSB; bit counter 0 -> ACK, cmd WRITE, core_txd = ack_in if byte counter 0, else 0 (master ACK on intermediate bytes); otherwise stay.
REQ-016 ACK + core_ack SHALL set ack_out <= core_rxd and, for a write, ack_vec[byte counter] <= core_rxd.
REQ-017 ACK + core_ack with byte counter != 0 SHALL decrement the byte counter, reload bit counter 7, and re-enter WRITE (sr shifted 1, cmd WRITE) or READ (cmd READ).
REQ-018 ACK + core_ack with byte counter 0 SHALL go to STOP (cmd STOP) if stop, else IDLE (cmd NOP) with cmd_ack pulse.
REQ-019 STOP + core_ack SHALL go to IDLE, cmd NOP, one-cycle cmd_ack pulse.
REQ-020 dout SHALL equal sr; after an L-byte read, first byte in dout[8L-1:8L-8], bits above 8L zero.
REQ-021 core_al SHALL force IDLE, cmd NOP, core_txd 0, no cmd_ack, within one cycle from any state; sr, ack_vec, dout held.
REQ-022 cmd_ack SHALL be high exactly one cycle per completed command; go is masked that cycle.

Reset
REQ-023 nReset low (async) or rst high (sync) SHALL set state IDLE, core_cmd NOP, core_txd 0, cmd_ack 0, ack_out 0, ack_vec all ones, sr/dout 0, counters 0, nack_abort 0, busy 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer without cmd_ack.

Configuration
REQ-025 With I2C_WORD_NACK_ABORT_EN defined, ACK completion on a write byte with core_rxd=1 and byte counter != 0 SHALL skip remaining bytes, set nack_abort=1, then follow REQ-018.
REQ-026 Without I2C_WORD_NACK_ABORT_EN, all L bytes SHALL be written regardless of NACK and nack_abort SHALL be tied 0.

Verification
REQ-027 NBYTES=2, start+write+stop, len=2, din=16'hA55A, slave ACKs all -> SDA bits A5 then 5A, ack_vec=2'b00, one cmd_ack after STOP.
REQ-028 read, len=2, ack_in=1, slave sends 3C,C3 -> core_txd 0 after byte 1, 1 after byte 2, dout=16'h3CC3, ack_out=1.
REQ-029 write, len=1, din=16'h00F0 -> only F0 sent, one ack bit, ack_vec[0] updated, ack_vec[1]=1.
REQ-030 len=0 and len=9 with NBYTES=2 -> both behave as len=2.
REQ-031 macro defined, write len=2, slave NACKs byte 1 with stop -> no second byte, nack_abort=1, STOP issued, cmd_ack; macro undefined -> both bytes sent, nack_abort=0.
REQ-032 core_al asserted during bit 3 of byte 2 -> IDLE next cycle, core_cmd NOP, no cmd_ack; nReset pulse mid-read -> all outputs per REQ-023.
